// File: rtl/y86_pipe_execute.sv
// Y86 pipeline E stage: computes valE/cnd, owns the ZF/SF/OF register, drives the E->M register.
// Latency: 1 cycle for single-cycle ops; WIDTH+1 for the iterative multiply (OPq ifun 4).
// Backpressure: in_ready = !busy && !m_stall; m_stall freezes M_* and cc; bubbles fill idle slots.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready instruction handshake from D stage
//   e_*               decoded E-stage instruction fields
//   cc_block          downstream exception: suppress condition-code writes
//   m_stall           hold the E->M register
//   busy              multiply in progress
//   cc                {ZF,SF,OF}
//   M_*               registered E->M pipeline outputs
module y86_pipe_execute #(
  parameter int WIDTH      = 64,
  parameter bit MUL_EN     = 1'b1,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [WIDTH-1:0] e_valB,
  input  logic [WIDTH-1:0] e_valC,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic [2:0]       e_stat,
  input  logic             cc_block,
  input  logic             m_stall,
  output logic             busy,
  output logic [2:0]       cc,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [2:0]       M_stat
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] R_NONE  = 4'hF;
  localparam logic [2:0] S_AOK   = 3'd1;
  localparam logic [2:0] S_INS   = 3'd4;

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             is_op, op_legal, mul_start, mul_step, mul_done;
  logic [WIDTH-1:0] val_e;
  logic             op_of;
  logic             cond, cnd;
  logic             cc_zf, cc_sf, cc_of;

  // Multiply working state plus the instruction fields that ride along with it.
  logic [WIDTH-1:0] mul_a, mul_b, mul_p, mul_p_nxt, mul_vala;
  logic [CW-1:0]    mul_cnt;
  logic [3:0]       mul_dste, mul_dstm;
  logic [2:0]       mul_stat;

  assign busy      = (state_q == ST_MUL);
  assign in_ready  = !busy && !m_stall;
  assign accept    = in_valid && in_ready;
  assign is_op     = (e_icode == I_OP);
  assign op_legal  = (e_ifun <= 4'd3) || ((e_ifun == 4'd4) && MUL_EN);
  assign mul_start = accept && is_op && (e_ifun == 4'd4) && MUL_EN;
  assign mul_p_nxt = mul_p + (mul_b[0] ? mul_a : '0);
  assign {cc_zf, cc_sf, cc_of} = cc;

  // valE and the signed-overflow flag for add/sub.
  always_comb begin
    val_e = '0;
    op_of = 1'b0;
    case (e_icode)
      I_OP: begin
        case (e_ifun)
          4'd0: begin
            val_e = e_valB + e_valA;
            op_of = (e_valA[WIDTH-1] == e_valB[WIDTH-1]) && (val_e[WIDTH-1] != e_valA[WIDTH-1]);
          end
          4'd1: begin
            val_e = e_valB - e_valA;
            op_of = (e_valB[WIDTH-1] != e_valA[WIDTH-1]) && (val_e[WIDTH-1] != e_valB[WIDTH-1]);
          end
          4'd2:    val_e = e_valB & e_valA;
          4'd3:    val_e = e_valB ^ e_valA;
          default: val_e = '0;
        endcase
      end
      I_RRMOV:         val_e = e_valA;
      I_IRMOV:         val_e = e_valC;
      I_RMMOV, I_MRMOV: val_e = e_valB + e_valC;
      I_CALL, I_PUSH:  val_e = e_valB - STEP;
      I_RET, I_POP:    val_e = e_valB + STEP;
      default:         val_e = '0;
    endcase
  end

  // Branch / cmov condition evaluated against the cc state before this instruction.
  always_comb begin
    case (e_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (cc_sf ^ cc_of) | cc_zf;
      4'd2:    cond = cc_sf ^ cc_of;
      4'd3:    cond = cc_zf;
      4'd4:    cond = !cc_zf;
      4'd5:    cond = !(cc_sf ^ cc_of);
      4'd6:    cond = !(cc_sf ^ cc_of) && !cc_zf;
      default: cond = 1'b0;
    endcase
    cnd = ((e_icode == I_RRMOV) || (e_icode == I_JXX)) ? cond : 1'b0;
  end

  // Multiply sequencer. The last step is also the M write, so it is held
  // back while M is stalled; earlier steps proceed regardless.
  always_comb begin
    state_d  = state_q;
    mul_step = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL: begin
        if (mul_cnt != LAST) begin
          mul_step = 1'b1;
        end else if (!m_stall) begin
          mul_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      mul_p    <= '0;
      mul_vala <= '0;
      mul_cnt  <= '0;
      mul_dste <= R_NONE;
      mul_dstm <= R_NONE;
      mul_stat <= S_AOK;
    end else if (mul_start) begin
      mul_a    <= e_valA;
      mul_b    <= e_valB;
      mul_p    <= '0;
      mul_vala <= e_valA;
      mul_cnt  <= '0;
      mul_dste <= e_dstE;
      mul_dstm <= e_dstM;
      mul_stat <= e_stat;
    end else if (mul_step) begin
      mul_p   <= mul_p_nxt;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      mul_cnt <= mul_cnt + CW'(1);
    end
  end

  // E->M register and condition codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc      <= 3'b100;
      M_valid <= 1'b0;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= R_NONE;
      M_dstM  <= R_NONE;
      M_stat  <= S_AOK;
    end else if (!m_stall) begin
      if (mul_done) begin
        M_valid <= 1'b1;
        M_icode <= I_OP;
        M_cnd   <= 1'b0;
        M_valE  <= mul_p_nxt;
        M_valA  <= mul_vala;
        M_dstE  <= mul_dste;
        M_dstM  <= mul_dstm;
        M_stat  <= mul_stat;
        if ((mul_stat == S_AOK) && !cc_block)
          cc <= {(mul_p_nxt == '0), mul_p_nxt[WIDTH-1], 1'b0};
      end else if (accept && !mul_start) begin
        M_valid <= 1'b1;
        M_icode <= e_icode;
        M_cnd   <= cnd;
        M_valE  <= val_e;
        M_valA  <= e_valA;
        M_dstE  <= ((e_icode == I_RRMOV) && !cnd) ? R_NONE : e_dstE;
        M_dstM  <= e_dstM;
        // An upstream fault takes precedence over an illegal-op report.
        M_stat  <= (e_stat != S_AOK) ? e_stat : ((is_op && !op_legal) ? S_INS : S_AOK);
        if (is_op && (e_ifun <= 4'd3) && (e_stat == S_AOK) && !cc_block)
          cc <= {(val_e == '0), val_e[WIDTH-1], op_of};
      end else begin
        // Bubble: nothing accepted, or a multiply just started / still running.
        M_valid <= 1'b0;
        M_icode <= I_NOP;
        M_cnd   <= 1'b0;
        M_valE  <= '0;
        M_valA  <= '0;
        M_dstE  <= R_NONE;
        M_dstM  <= R_NONE;
        M_stat  <= S_AOK;
      end
    end
  end

endmodule
